// File: rtl/dmem_pkg.sv
// Shared types and helpers for the M-stage data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam int WORD_BYTES = 4;
   localparam int MAX_WAIT   = 15;

   // Fault on a misaligned address or on any bit above the word index.
   function automatic logic addrFault(input logic [31:0] addr, input int idxBits);
      logic [31:0] w_upper;
      logic [31:0] w_offset;
      w_upper  = addr >> (idxBits + $clog2(WORD_BYTES));
      w_offset = addr & 32'(WORD_BYTES - 1);
      return (w_offset != 32'd0) || (w_upper != 32'd0);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with registered read data and no reset.
module dmem_array #(
   parameter int DEPTH_WORDS = 256
) (
   input  logic                           clk,
   input  logic                           i_we,
   input  logic                           i_re,
   input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
   input  logic [31:0]                    i_wdata,
   output logic [31:0]                    o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_idx] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_idx];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: accepts one load/store, stalls for the wait
// states, then returns the loaded word or a fault in the RESP cycle.
import dmem_pkg::*;

module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReqM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        MemStallM,
   output logic        MemErrM
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

   state_t            r_state;
   state_t            w_nextState;
   logic [CNT_W-1:0]  r_count;
   logic [IDX_W-1:0]  r_idx;
   logic [31:0]       r_wdata;
   logic              r_we;
   logic              r_fault;
   logic              r_dataOk;

   logic              w_accept;
   logic              w_toResp;
   logic              w_reqFault;
   logic              w_curWe;
   logic              w_curFault;
   logic [IDX_W-1:0]  w_curIdx;
   logic              w_arrRe;
   logic              w_arrWe;
   logic [31:0]       w_arrRdata;

   always_comb begin
      w_nextState = r_state;
      MemStallM   = 1'b0;
      MemErrM     = 1'b0;
      case (r_state)
         IDLE: begin
            if (MemReqM) begin
               MemStallM   = 1'b1;
               w_nextState = (WAIT_STATES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            MemStallM = 1'b1;
            if (r_count == CNT_W'(1)) begin
               w_nextState = RESP;
            end
         end
         RESP: begin
            MemErrM     = r_fault;
            w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // With zero wait states the read happens on the accept edge, so the array
   // must see the live request rather than the not-yet-written latch.
   assign w_accept   = (r_state == IDLE) && MemReqM;
   assign w_toResp   = (w_nextState == RESP);
   assign w_reqFault = addrFault(ALUResultM, IDX_W);
   assign w_curWe    = (r_state == IDLE) ? MemWriteM : r_we;
   assign w_curFault = (r_state == IDLE) ? w_reqFault : r_fault;
   assign w_curIdx   = (r_state == IDLE) ? ALUResultM[IDX_W+1:2] : r_idx;
   assign w_arrRe    = w_toResp && !w_curWe && !w_curFault;
   assign w_arrWe    = (r_state == RESP) && r_we && !r_fault;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_idx    <= '0;
         r_wdata  <= '0;
         r_we     <= 1'b0;
         r_fault  <= 1'b0;
         r_dataOk <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_accept) begin
            r_count <= WAIT_INIT;
            r_idx   <= ALUResultM[IDX_W+1:2];
            r_wdata <= WriteDataM;
            r_we    <= MemWriteM;
            r_fault <= w_reqFault;
         end else if (r_state == WAIT) begin
            r_count <= r_count - CNT_W'(1);
         end
         // A fault zeroes the output; a good load exposes the array register.
         if (w_toResp) begin
            if (w_curFault) begin
               r_dataOk <= 1'b0;
            end else if (!w_curWe) begin
               r_dataOk <= 1'b1;
            end
         end
      end
   end

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_array (
      .clk     (clk),
      .i_we    (w_arrWe),
      .i_re    (w_arrRe),
      .i_idx   (w_curIdx),
      .i_wdata (r_wdata),
      .o_rdata (w_arrRdata)
   );

   assign ReadDataM = r_dataOk ? w_arrRdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and
// one with none, driven through a linear sequence of accesses.
module tb_dmem_responder;

   logic        clk;
   logic        reset;

   logic        reqA;
   logic        weA;
   logic [31:0] addrA;
   logic [31:0] wdataA;
   logic [31:0] rdA;
   logic        stallA;
   logic        errA;

   logic        reqB;
   logic        weB;
   logic [31:0] addrB;
   logic [31:0] wdataB;
   logic [31:0] rdB;
   logic        stallB;
   logic        errB;

   int passCount;
   int totalCount;

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dutA (
      .clk        (clk),
      .reset      (reset),
      .MemReqM    (reqA),
      .MemWriteM  (weA),
      .ALUResultM (addrA),
      .WriteDataM (wdataA),
      .ReadDataM  (rdA),
      .MemStallM  (stallA),
      .MemErrM    (errA)
   );

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dutB (
      .clk        (clk),
      .reset      (reset),
      .MemReqM    (reqB),
      .MemWriteM  (weB),
      .ALUResultM (addrB),
      .WriteDataM (wdataB),
      .ReadDataM  (rdB),
      .MemStallM  (stallB),
      .MemErrM    (errB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic req, input logic we,
                                input logic [31:0] addr, input logic [31:0] data);
      reqA   = req;
      weA    = we;
      addrA  = addr;
      wdataA = data;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      totalCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   // Full access on the two-wait-state instance; inputs are scrambled after
   // accept so any late sampling shows up in the result.
   task automatic runAccessA(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] expRd,
                             input logic expErr);
      applyStimulus(1'b1, we, addr, data);
      checkOutput({tag, " accept stall"}, 32'(stallA), 32'd1);
      tick();
      applyStimulus(1'b0, ~we, addr ^ 32'h4, ~data);
      checkOutput({tag, " wait1 stall"}, 32'(stallA), 32'd1);
      tick();
      checkOutput({tag, " wait2 stall"}, 32'(stallA), 32'd1);
      tick();
      checkOutput({tag, " resp stall"}, 32'(stallA), 32'd0);
      checkOutput({tag, " resp err"}, 32'(errA), 32'(expErr));
      checkOutput({tag, " resp data"}, rdA, expRd);
      tick();
      checkOutput({tag, " idle stall"}, 32'(stallA), 32'd0);
      checkOutput({tag, " idle err"}, 32'(errA), 32'd0);
      checkOutput({tag, " idle data"}, rdA, expRd);
   endtask

   initial begin
      passCount  = 0;
      totalCount = 0;
      reset  = 1'b0;
      reqA   = 1'b0; weA = 1'b0; addrA = 32'd0; wdataA = 32'd0;
      reqB   = 1'b0; weB = 1'b0; addrB = 32'd0; wdataB = 32'd0;
      tick();
      tick();
      checkOutput("reset A data", rdA, 32'd0);
      checkOutput("reset A stall", 32'(stallA), 32'd0);
      checkOutput("reset A err", 32'(errA), 32'd0);
      checkOutput("reset B data", rdB, 32'd0);
      reset = 1'b1;
      tick();

      runAccessA("preload st 0x10", 1'b1, 32'h10, 32'h11112222, 32'd0, 1'b0);
      runAccessA("st 0x40", 1'b1, 32'h40, 32'hDEADBEEF, 32'd0, 1'b0);
      runAccessA("ld 0x40", 1'b0, 32'h40, 32'd0, 32'hDEADBEEF, 1'b0);

      // Reset arrives in the middle of a store's wait period.
      applyStimulus(1'b1, 1'b1, 32'h10, 32'h99999999);
      checkOutput("rst-mid accept stall", 32'(stallA), 32'd1);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("rst-mid wait stall", 32'(stallA), 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("rst-mid stall", 32'(stallA), 32'd0);
      checkOutput("rst-mid err", 32'(errA), 32'd0);
      checkOutput("rst-mid data", rdA, 32'd0);
      tick();
      reset = 1'b1;
      tick();
      runAccessA("ld 0x10 after rst", 1'b0, 32'h10, 32'd0, 32'h11112222, 1'b0);

      runAccessA("misaligned st 0x42", 1'b1, 32'h42, 32'h0BADF00D, 32'd0, 1'b1);
      runAccessA("ld 0x40 unchanged", 1'b0, 32'h40, 32'd0, 32'hDEADBEEF, 1'b0);
      runAccessA("ld 0x400 range", 1'b0, 32'h400, 32'd0, 32'd0, 1'b1);
      runAccessA("st 0x3FC last", 1'b1, 32'h3FC, 32'h12345678, 32'd0, 1'b0);

      // Back-to-back loads with the request held high through RESP.
      applyStimulus(1'b1, 1'b0, 32'h3FC, 32'd0);
      checkOutput("b2b first accept stall", 32'(stallA), 32'd1);
      tick();
      checkOutput("b2b first wait1 stall", 32'(stallA), 32'd1);
      tick();
      checkOutput("b2b first wait2 stall", 32'(stallA), 32'd1);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h40, 32'd0);
      checkOutput("b2b first resp stall", 32'(stallA), 32'd0);
      checkOutput("b2b first resp data", rdA, 32'h12345678);
      checkOutput("b2b first resp err", 32'(errA), 32'd0);
      tick();
      checkOutput("b2b second accept stall", 32'(stallA), 32'd1);
      checkOutput("b2b second accept data", rdA, 32'h12345678);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'd0);
      checkOutput("b2b second wait1 stall", 32'(stallA), 32'd1);
      tick();
      checkOutput("b2b second wait2 stall", 32'(stallA), 32'd1);
      tick();
      checkOutput("b2b second resp stall", 32'(stallA), 32'd0);
      checkOutput("b2b second resp data", rdA, 32'hDEADBEEF);
      tick();
      checkOutput("b2b idle stall", 32'(stallA), 32'd0);

      // Zero wait states: one stall cycle, RESP on the next cycle.
      reqB = 1'b1; weB = 1'b1; addrB = 32'h0; wdataB = 32'hCAFEF00D;
      #1;
      checkOutput("ws0 st accept stall", 32'(stallB), 32'd1);
      tick();
      reqB = 1'b0; weB = 1'b0; wdataB = 32'd0;
      #1;
      checkOutput("ws0 st resp stall", 32'(stallB), 32'd0);
      checkOutput("ws0 st resp err", 32'(errB), 32'd0);
      checkOutput("ws0 st resp data", rdB, 32'd0);
      tick();
      reqB = 1'b1; weB = 1'b0; addrB = 32'h0;
      #1;
      checkOutput("ws0 ld accept stall", 32'(stallB), 32'd1);
      tick();
      reqB = 1'b0;
      #1;
      checkOutput("ws0 ld resp stall", 32'(stallB), 32'd0);
      checkOutput("ws0 ld resp data", rdB, 32'hCAFEF00D);
      checkOutput("ws0 ld resp err", 32'(errB), 32'd0);
      tick();
      checkOutput("ws0 idle data hold", rdB, 32'hCAFEF00D);
      checkOutput("ws0 idle stall", 32'(stallB), 32'd0);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
